// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM window streamer: FSM encoding and
// the configuration legality check.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    // The FIFO must absorb every read in flight plus the word being popped.
    function automatic bit cfg_ok(input int fifo_depth, input int rd_lat);
        return (rd_lat >= 1) && (rd_lat <= 4) && (fifo_depth >= rd_lat + 1);
    endfunction

endpackage

// File: rtl/bram_stream_reader_stream_fifo.sv
// Show-ahead FIFO with synchronous flush; a write into an empty FIFO is
// visible on the head only in the following cycle.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a programmable address window of an external read-only BRAM onto
// a valid/ready channel, with credit-guarded issue, loop mode and abort.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_W     = 1024,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              loop_mode,
    input  logic              abort,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int LEN_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    if (!cfg_ok(FIFO_DEPTH, RD_LAT)) begin : g_bad_cfg
        $error("bram_stream_reader: need RD_LAT in 1..4 and FIFO_DEPTH >= RD_LAT+1");
    end

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, base_q;
    logic [LEN_W-1:0]  remain, len_q;
    logic              loop_q, done_q;
    logic [RD_LAT:1]   vld_pipe, lst_pipe;
    logic [CNT_W-1:0]  inflight, occupancy;
    logic [FCNT_W-1:0] fifo_count;
    logic [DATA_W:0]   head;
    logic              fifo_empty, pop, issue, last_issue, flush, accept;

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LAT; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    // Conservative credit: every read in the pipe already owns a FIFO slot.
    assign pop        = out_valid & out_ready;
    assign occupancy  = inflight + CNT_W'(fifo_count) - CNT_W'(pop);
    assign issue      = (state == RUN) & ~abort & (occupancy < CNT_W'(FIFO_DEPTH));
    assign last_issue = (remain == LEN_W'(1));
    assign flush      = abort & (state != IDLE);
    assign accept     = (state == IDLE) & start & (len != '0);

    assign mem_en    = issue;
    assign mem_addr  = addr;
    assign out_valid = ~fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = ~fifo_empty & head[DATA_W];
    assign busy      = (state != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (issue && last_issue && !loop_q) state_nxt = DRAIN;
            DRAIN:   if (abort || (pop && head[DATA_W])) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            base_q   <= '0;
            remain   <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            done_q <= ((state == IDLE) && start && (len == '0)) ||
                      ((state == DRAIN) && !abort && pop && head[DATA_W]);
            if (flush) begin
                vld_pipe <= '0;
                lst_pipe <= '0;
            end else begin
                vld_pipe[1] <= issue;
                lst_pipe[1] <= last_issue;
                for (int i = 2; i <= RD_LAT; i++) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    lst_pipe[i] <= lst_pipe[i-1];
                end
            end
            if (accept) begin
                base_q <= base_addr;
                len_q  <= len;
                loop_q <= loop_mode;
                addr   <= base_addr;
                remain <= len;
            end else if (issue) begin
                // Loop mode rewinds on the last issue so passes run back to back.
                if (last_issue && loop_q) begin
                    addr   <= base_q;
                    remain <= len_q;
                end else begin
                    addr   <= addr + ADDR_W'(1);
                    remain <= remain - LEN_W'(1);
                end
            end
        end
    end

    stream_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (vld_pipe[RD_LAT] & ~flush),
        .wr_data ({lst_pipe[RD_LAT], mem_rdata}),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench: a table of transfers on an RD_LAT=1 instance, hand-written
// corner sequences, and a randomly stalled RD_LAT=3 instance.
module tb_bram_stream_reader;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          a_start, a_loop, a_abort, a_ready;
    logic [AW-1:0] a_base, a_mem_addr;
    logic [AW:0]   a_len;
    logic [DW-1:0] a_rdata, a_data;
    logic          a_mem_en, a_valid, a_last, a_busy, a_done;

    logic          b_start, b_loop, b_abort, b_ready;
    logic [AW-1:0] b_base, b_mem_addr;
    logic [AW:0]   b_len;
    logic [DW-1:0] b_rdata, b_data, b_p1, b_p2;
    logic          b_mem_en, b_valid, b_last, b_busy, b_done;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hD00D_0000 | {26'd0, a};
    endfunction

    // BRAM models with 1 and 3 cycles of read latency
    always @(posedge clk) a_rdata <= word(a_mem_addr);
    always @(posedge clk) begin
        b_p1    <= word(b_mem_addr);
        b_p2    <= b_p1;
        b_rdata <= b_p2;
    end

    bram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base), .len(a_len),
        .loop_mode(a_loop), .abort(a_abort), .mem_en(a_mem_en), .mem_addr(a_mem_addr),
        .mem_rdata(a_rdata), .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
        .out_last(a_last), .busy(a_busy), .done(a_done));

    bram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base), .len(b_len),
        .loop_mode(b_loop), .abort(b_abort), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .mem_rdata(b_rdata), .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
        .out_last(b_last), .busy(b_busy), .done(b_done));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic          loop;
        int            abort_at;      // 0 = never abort
        bit            busy_start;    // pulse a second start mid-transfer
        int            exp_count;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_lastaddr;
        int            exp_nlast;
        int            exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int id);
        int hs = 0, nlast = 0, ndone = 0, cyc = 0, stop_at = -1, abort_cyc = -1;
        int first_en = -1, first_val = -1, first_hs = -1, last_hs = -1;
        bit abort_pend = 0;
        logic [AW-1:0] exp_a, first_a = '0, last_a = '0;
        @(negedge clk);
        a_base = v.base; a_len = v.len; a_loop = v.loop; a_ready = 1'b1; a_abort = 1'b0;
        a_start = 1'b1;
        while (stop_at < 0 || cyc < stop_at) begin
            @(negedge clk);
            cyc++;
            a_start = v.busy_start && (cyc == 3);
            if (a_start) begin a_base = 6'd40; a_len = 7'd2; end
            a_abort = abort_pend;
            a_ready = !abort_pend;
            if (abort_pend) begin abort_pend = 0; abort_cyc = cyc; stop_at = cyc + 5; end
            #1;
            if (a_mem_en && first_en < 0) first_en = cyc;
            if (a_valid && first_val < 0) first_val = cyc;
            if (a_done) ndone++;
            check($sformatf("v%0d_done_busy_excl", id), a_done & a_busy, 0);
            if (abort_cyc >= 0 && cyc > abort_cyc) begin
                check($sformatf("v%0d_post_abort_valid", id), a_valid, 0);
                check($sformatf("v%0d_post_abort_busy", id), a_busy, 0);
            end
            if (a_valid && a_ready) begin
                exp_a = AW'(int'(v.base) + hs % int'(v.len));
                check($sformatf("v%0d_data%0d", id, hs), a_data, word(exp_a));
                check($sformatf("v%0d_last%0d", id, hs), a_last,
                      (hs % int'(v.len)) == int'(v.len) - 1);
                if (a_last) nlast++;
                if (first_hs < 0) begin first_hs = cyc; first_a = a_data[AW-1:0]; end
                last_hs = cyc;
                last_a = a_data[AW-1:0];
                hs++;
                if (hs == v.abort_at) abort_pend = 1;
            end
            if (a_done && stop_at < 0) stop_at = cyc + 3;
            if (cyc > 400 && stop_at < 0) begin
                check($sformatf("v%0d_timeout", id), 1, 0);
                stop_at = cyc;
            end
        end
        a_abort = 1'b0;
        check($sformatf("v%0d_count", id), hs, v.exp_count);
        check($sformatf("v%0d_first_addr", id), first_a, v.exp_first);
        check($sformatf("v%0d_last_addr", id), last_a, v.exp_lastaddr);
        check($sformatf("v%0d_nlast", id), nlast, v.exp_nlast);
        check($sformatf("v%0d_ndone", id), ndone, v.exp_done);
        check($sformatf("v%0d_latency", id), first_val - first_en, 2);
        if (abort_cyc < 0)
            check($sformatf("v%0d_throughput", id), last_hs - first_hs, hs - 1);
    endtask

    initial begin
        int hs, ndone, issued, cyc, stop_at, first_en, first_val;
        logic prev_stall, prev_last;
        logic [DW-1:0] prev_data;
        vec_t post;

        rst_n = 1'b0;
        a_start = 0; a_loop = 0; a_abort = 0; a_ready = 1; a_base = '0; a_len = '0;
        b_start = 0; b_loop = 0; b_abort = 0; b_ready = 0; b_base = '0; b_len = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_valid", a_valid, 0);
        check("rst_last", a_last, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        rst_n = 1'b1;

        // zero-length start: no read, done pulse next cycle
        @(negedge clk);
        a_base = 6'd3; a_len = '0; a_start = 1'b1;
        #1 check("len0_mem_en0", a_mem_en, 0);
        @(negedge clk);
        a_start = 1'b0;
        #1;
        check("len0_done", a_done, 1);
        check("len0_busy", a_busy, 0);
        check("len0_mem_en1", a_mem_en, 0);
        @(negedge clk);
        #1;
        check("len0_done_clear", a_done, 0);
        check("len0_mem_en2", a_mem_en, 0);

        //         base   len    loop  abt bs  cnt first  last   nl dn
        vecs[0] = '{6'd0,  7'd64, 1'b0, 0, 0, 64, 6'd0,  6'd63, 1, 1};
        vecs[1] = '{6'd62, 7'd4,  1'b0, 0, 0, 4,  6'd62, 6'd1,  1, 1};
        vecs[2] = '{6'd5,  7'd3,  1'b1, 8, 0, 8,  6'd5,  6'd6,  2, 0};
        vecs[3] = '{6'd10, 7'd1,  1'b0, 0, 0, 1,  6'd10, 6'd10, 1, 1};
        vecs[4] = '{6'd63, 7'd64, 1'b0, 0, 0, 64, 6'd63, 6'd62, 1, 1};
        vecs[5] = '{6'd20, 7'd6,  1'b0, 0, 1, 6,  6'd20, 6'd25, 1, 1};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // reset mid-RUN while the FIFO holds 3 stalled words
        @(negedge clk);
        a_base = 6'd9; a_len = 7'd20; a_loop = 1'b0; a_ready = 1'b0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stall_valid", a_valid, 1);
        check("stall_head", a_data, word(6'd9));
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_mem_en", a_mem_en, 0);
        check("midrst_mem_addr", a_mem_addr, 0);
        check("midrst_valid", a_valid, 0);
        check("midrst_last", a_last, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        rst_n = 1'b1;
        a_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("postrst_valid", a_valid, 0);
            check("postrst_done", a_done, 0);
        end
        post = '{6'd7, 7'd5, 1'b0, 0, 0, 5, 6'd7, 6'd11, 1, 1};
        run_vec(post, 9);

        // RD_LAT=3 instance under random backpressure
        hs = 0; ndone = 0; issued = 0; cyc = 0; stop_at = -1; first_en = -1; first_val = -1;
        prev_stall = 0; prev_last = 0; prev_data = '0;
        @(negedge clk);
        b_base = '0; b_len = 7'd64; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (stop_at < 0 || cyc < stop_at) begin
            b_ready = ($urandom_range(0, 99) < 30);
            #1;
            if (b_mem_en && first_en < 0) first_en = cyc;
            if (b_valid && first_val < 0) first_val = cyc;
            check("b_credit", (issued - hs) <= 4, 1);
            if (prev_stall) begin
                check("b_hold_valid", b_valid, 1);
                check("b_hold_data", b_data, prev_data);
                check("b_hold_last", b_last, prev_last);
            end
            if (b_valid && b_ready) begin
                check($sformatf("b_data%0d", hs), b_data, word(AW'(hs)));
                check($sformatf("b_last%0d", hs), b_last, hs == 63);
                hs++;
            end
            if (b_mem_en) issued++;
            if (b_done) ndone++;
            check("b_done_busy_excl", b_done & b_busy, 0);
            prev_stall = b_valid & ~b_ready;
            prev_data = b_data;
            prev_last = b_last;
            if (b_done && stop_at < 0) stop_at = cyc + 3;
            if (cyc > 3000 && stop_at < 0) begin
                check("b_timeout", 1, 0);
                stop_at = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check("b_count", hs, 64);
        check("b_issued", issued, 64);
        check("b_ndone", ndone, 1);
        check("b_latency", first_val - first_en, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Parametrised successor to the fixed 64-entry BRAM sweep sequencer. Streams a programmable window of a single-port read-only BRAM onto a valid/ready output channel.
- Adds start/len/base programming, configurable BRAM read latency, backpressure through a credit-guarded output FIFO, a loop mode, abort, and done/last signalling.
- Sits between a coefficient/data BRAM and the compute datapath. The BRAM is external; this block drives its address and enable ports.

Parameters:
DATA_W, 1024, width of a BRAM word and of out_data
ADDR_W, 6, BRAM address width; depth = 2**ADDR_W
RD_LAT, 1, BRAM read latency in cycles from mem_en to mem_rdata valid (legal 1..4)
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1 (elaboration error otherwise)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDR_W  first address; latched on accepted start
len  in  ADDR_W+1  number of words per pass (0..2**ADDR_W); latched on accepted start
loop_mode  in  1  1 = repeat passes until abort; latched on accepted start
abort  in  1  stop and flush; ignored in IDLE
mem_en  out  1  BRAM read enable (read issued this cycle)
mem_addr  out  ADDR_W  BRAM read address
mem_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after mem_en
out_data  out  DATA_W  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
out_last  out  1  marks the final word of each pass, qualified by out_valid
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse when a non-loop transfer fully drains

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, address/counters=0, in-flight tracker cleared, FIFO emptied. mem_en=0, mem_addr=0, out_valid=0, out_last=0, busy=0, done=0. Reset mid-transfer discards all data, with no done.
- States: IDLE, RUN, DRAIN.
  - IDLE: if start and len!=0, go to RUN and latch base_addr, len and loop_mode. If start and len==0, stay in IDLE and pulse done the next cycle.
  - RUN: issues reads. After the last address of a pass is issued, non-loop goes to DRAIN; loop mode reloads the address from base and the remaining count from len, with no bubble.
  - DRAIN: no issue. When the word tagged last is handshaken, go to IDLE and pulse done in the following cycle.
- Issue rule (RUN only): mem_en = (inflight + fifo_count - pop) < FIFO_DEPTH, where pop = out_valid & out_ready. This guarantees no FIFO overflow. mem_addr is a registered address counter; it is never X.
- Address arithmetic is modulo 2**ADDR_W: base=62, len=4 reads 62, 63, 0, 1.
- Read pipeline: a RD_LAT-deep shift register carries {valid, last} alongside each read. mem_rdata is written to the FIFO in cycle c+RD_LAT for an issue in cycle c.
- FIFO is show-ahead. Minimum latency from mem_en to out_valid is RD_LAT+1 cycles.
- Sustains 1 word/cycle while out_ready=1.
- out_valid/out_data/out_last must stay stable while out_valid & !out_ready.
- out_last=1 on the word of each pass whose in-pass index is len-1.
- Simultaneous write and pop on a full FIFO is legal. Simultaneous write and pop on an empty FIFO must not bypass; data appears the next cycle.
- abort in RUN/DRAIN: the next cycle is IDLE, the FIFO is flushed, in-flight valid bits are cleared (late mem_rdata ignored), out_valid=0 and no done. abort takes priority over a same-cycle last handshake.
- start while busy is ignored.
- done and busy are never high together.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) and the legality check FIFO_DEPTH>=RD_LAT+1.
- One sub-module, stream_fifo: parametrised DATA_W+1 wide, FIFO_DEPTH deep, show-ahead, with a synchronous flush input and a count output.
- Sequencer, credit logic and latency shift register stay in the top module.

Test Plan:
- Reset, then start base=0, len=64, loop=0, out_ready=1, RD_LAT=1 -> 64 words in address order 0..63 on consecutive cycles. First out_valid 2 cycles after first mem_en. out_last on word 63 only. done pulses once.
- base=62, len=4 -> data from addresses 62, 63, 0, 1. out_last on the word from address 1.
- RD_LAT=3, FIFO_DEPTH=4, out_ready toggled with a random 30% duty -> no lost or duplicated words, inflight+fifo_count<=4 always, data held stable while stalled.
- loop_mode=1, base=5, len=3, abort after 8 handshakes -> sequence 5,6,7,5,6,7,5,6. out_last on every 7. After abort: IDLE next cycle, out_valid=0, no done, late mem_rdata not output.
- start with len=0 -> no mem_en, done pulse next cycle. start asserted while busy -> ignored, current transfer unaffected.
- rst_n low for 1 cycle mid-RUN with the FIFO holding 3 words -> all outputs return to reset values at the next edge. A new start afterwards streams from base correctly.
